stick_sorter: RTL

STICK_SORTER -- requirements
Module: stick_sorter

---
 rtl/stick_pkg.sv | 18 +
 rtl/frame_pacer.sv | 39 +++
 rtl/stick_sorter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stick_pkg.sv
// Shared constants and FSM encoding for the stick sorter and the stick renderer.
package stick_pkg;

    localparam int NUM_STICKS    = 8;
    localparam int HEIGHT_W      = 9;
    localparam int STICK_WIDTH   = 40;
    localparam int STICK_SPACING = 80;
    localparam int TOP_EDGE      = 100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_SWAP    = 3'd3,
        ST_DONE    = 3'd4
    } sort_state_t;

endpackage

// File: rtl/frame_pacer.sv
// Turns vblnk rising edges into frame ticks and emits a one-cycle step pulse
// on every FRAMES_PER_STEP-th tick seen while enabled.
module frame_pacer #(
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic vblnk,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_STEP - 1);

    logic             vblnk_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             tick;

    // A long vblnk pulse produces a single tick: only the low-to-high edge counts.
    assign tick = vblnk & ~vblnk_q;
    assign step = enable & tick & (frame_cnt == LAST_CNT);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vblnk_q   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblnk_q <= vblnk;
            if (clear) begin
                frame_cnt <= '0;
            end else if (enable && tick) begin
                frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stick_sorter.sv
// Frame-paced bubble sort of NUM_STICKS heights with early exit on a clean pass,
// exposing the working array and comparison cursor for on-screen animation.
module stick_sorter
    import stick_pkg::*;
#(
    parameter int NUM_STICKS      = stick_pkg::NUM_STICKS,
    parameter int HEIGHT_W        = stick_pkg::HEIGHT_W,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic                           pclk,
    input  logic                           rst_n,
    input  logic                           vblnk,
    input  logic                           start,
    input  logic [NUM_STICKS*HEIGHT_W-1:0] init_heights,
    output logic [NUM_STICKS*HEIGHT_W-1:0] heights,
    output logic [2:0]                     cmp_idx,
    output logic [3:0]                     sorted_from,
    output logic                           last_swap,
    output logic                           busy,
    output logic                           done
);

    sort_state_t         state;
    logic [HEIGHT_W-1:0] h [NUM_STICKS];
    logic [2:0]          idx;
    logic [3:0]          limit;
    logic                pass_swap;

    logic                load;
    logic                step;
    logic [HEIGHT_W-1:0] left;
    logic [HEIGHT_W-1:0] right;
    logic                greater;
    logic                advance;
    logic                end_of_pass;
    logic                pass_swapped;
    logic                finish;

    assign load         = start && (state == ST_IDLE || state == ST_DONE);
    assign left         = h[idx];
    assign right        = h[idx + 3'd1];
    assign greater      = left > right;
    assign advance      = (state == ST_COMPARE && !greater) || (state == ST_SWAP);
    assign end_of_pass  = ({1'b0, idx} + 4'd1) == (limit - 4'd1);
    assign pass_swapped = pass_swap || (state == ST_SWAP);
    assign finish       = end_of_pass && (!pass_swapped || limit == 4'd2);

    frame_pacer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_pacer (
        .pclk  (pclk),
        .rst_n (rst_n),
        .vblnk (vblnk),
        .clear (load),
        .enable(state == ST_WAIT),
        .step  (step)
    );

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            // NOTE: the height array is reset element by element because it drives a visible output.
            for (int k = 0; k < NUM_STICKS; k++) h[k] <= '0;
            idx       <= '0;
            limit     <= 4'(NUM_STICKS);
            pass_swap <= 1'b0;
            last_swap <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_STICKS; k++) h[k] <= init_heights[k*HEIGHT_W +: HEIGHT_W];
                        idx       <= '0;
                        limit     <= 4'(NUM_STICKS);
                        pass_swap <= 1'b0;
                        last_swap <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: if (step) state <= ST_COMPARE;
                ST_COMPARE: begin
                    if (greater) state <= ST_SWAP;
                    else         last_swap <= 1'b0;
                end
                ST_SWAP: begin
                    h[idx]        <= right;
                    h[idx + 3'd1] <= left;
                    last_swap     <= 1'b1;
                    pass_swap     <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            // NOTE: this block follows the case so its assignments win (e.g. pass_swap cleared on a new pass).
            if (advance) begin
                if (!end_of_pass) begin
                    idx   <= idx + 3'd1;
                    state <= ST_WAIT;
                end else if (finish) begin
                    limit <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    limit     <= limit - 4'd1;
                    idx       <= '0;
                    pass_swap <= 1'b0;
                    state     <= ST_WAIT;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_STICKS; k++) begin : g_pack
        assign heights[k*HEIGHT_W +: HEIGHT_W] = h[k];
    end

    assign cmp_idx     = idx;
    assign sorted_from = limit;

endmodule
